// File: rtl/regfile_completion_checker_if.sv
// Port bundle for the register-file completion checker: snooped write port,
// check-slot programming, and the status/result outputs.
interface regfile_completion_checker_if #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_CHECKS = 4,
  parameter int CYCLE_W    = 16
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  // No backpressure anywhere: wr_en, cfg_we and start are single-cycle qualifiers
  // sampled on the rising edge; the status outputs are level signals.
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [XLEN-1:0]    wr_data;
  logic               cfg_we;
  logic [CW-1:0]      cfg_idx;
  logic               cfg_en;
  logic [AW-1:0]      cfg_reg;
  logic [XLEN-1:0]    cfg_val;
  logic               start;
  logic               busy;
  logic               done;
  logic               pass;
  logic               fail;
  logic               cfg_err;
  logic [CYCLE_W-1:0] cycle_count;
  logic [CW-1:0]      fail_idx;
  logic [1:0]         state_dbg;

  modport master (
    output wr_en, wr_addr, wr_data, cfg_we, cfg_idx, cfg_en, cfg_reg, cfg_val, start,
    input  busy, done, pass, fail, cfg_err, cycle_count, fail_idx, state_dbg
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, cfg_we, cfg_idx, cfg_en, cfg_reg, cfg_val, start,
    output busy, done, pass, fail, cfg_err, cycle_count, fail_idx, state_dbg
  );
endinterface

// File: rtl/regfile_completion_checker.sv
// Shadows register-file writes and declares PASS once every enabled check slot
// holds for STABLE_CYCLES consecutive cycles, or FAIL after TIMEOUT RUN cycles.
module regfile_completion_checker #(
  parameter int XLEN          = 32,
  parameter int NUM_REGS      = 32,
  parameter int NUM_CHECKS    = 4,
  parameter int CYCLE_W       = 16,
  parameter int TIMEOUT       = 60,
  parameter int STABLE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  regfile_completion_checker_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int MW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    shadow   [NUM_REGS];
  logic               slot_en  [NUM_CHECKS];
  logic [AW-1:0]      slot_reg [NUM_CHECKS];
  logic [XLEN-1:0]    slot_val [NUM_CHECKS];
  logic [MW-1:0]      match_cnt_q;
  logic [CYCLE_W-1:0] cycle_count_q;
  logic [CW-1:0]      fail_idx_q;
  logic               cfg_err_q;

  logic               any_en, all_match, miss_found, stable_hit, timeout_hit, start_ok;
  logic [CW-1:0]      first_miss;

  // Slot comparison works on the registered shadow, so a write is seen one cycle later.
  always_comb begin
    any_en     = 1'b0;
    all_match  = 1'b1;
    miss_found = 1'b0;
    first_miss = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      any_en = any_en | slot_en[i];
      if (slot_en[i] && (shadow[slot_reg[i]] != slot_val[i])) begin
        all_match = 1'b0;
        if (!miss_found) begin
          first_miss = CW'(i);
          miss_found = 1'b1;
        end
      end
    end
    all_match = all_match & any_en;
  end

  assign stable_hit  = all_match && ((int'(match_cnt_q) + 1) == STABLE_CYCLES);
  assign timeout_hit = (int'(cycle_count_q) + 1) == TIMEOUT;
  assign start_ok    = bus.start && any_en && (state_q != S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // PASS is tested before timeout so a stable match on the last cycle still passes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (stable_hit)       state_d = S_PASS;
        else if (timeout_hit) state_d = S_FAIL;
      end
      default: begin
        if (bus.start && any_en) state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_q <= '0;
      match_cnt_q   <= '0;
      fail_idx_q    <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_err_q <= (state_q != S_RUN) && bus.start && !any_en;
      if (state_q == S_RUN) begin
        cycle_count_q <= cycle_count_q + 1'b1;
        match_cnt_q   <= all_match ? match_cnt_q + 1'b1 : '0;
        if (!stable_hit && timeout_hit) fail_idx_q <= first_miss;
      end else if (start_ok) begin
        cycle_count_q <= '0;
        match_cnt_q   <= '0;
        fail_idx_q    <= '0;
      end
    end
  end

  // Snooping never stops; slot programming is frozen while a run is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) shadow[r] <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        slot_en[i]  <= 1'b0;
        slot_reg[i] <= '0;
        slot_val[i] <= '0;
      end
    end else begin
      if (bus.wr_en && (bus.wr_addr != '0)) shadow[bus.wr_addr] <= bus.wr_data;
      if (bus.cfg_we && (state_q != S_RUN) && (int'(bus.cfg_idx) < NUM_CHECKS)) begin
        slot_en[bus.cfg_idx]  <= bus.cfg_en;
        slot_reg[bus.cfg_idx] <= bus.cfg_reg;
        slot_val[bus.cfg_idx] <= bus.cfg_val;
      end
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_PASS) || (state_q == S_FAIL);
  assign bus.pass        = (state_q == S_PASS);
  assign bus.fail        = (state_q == S_FAIL);
  assign bus.cfg_err     = cfg_err_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.fail_idx    = fail_idx_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_regfile_completion_checker.sv
// Bench for regfile_completion_checker: scheduled snoop writes per RUN cycle, an
// outcome model over those schedules, and a monitor that scores each result.
module tb_regfile_completion_checker;
  localparam int XLEN = 32, NUM_REGS = 32, NUM_CHECKS = 4, CYCLE_W = 16;
  localparam int TIMEOUT = 60, STABLE = 2;
  localparam int AW = 5, CW = 2;
  localparam int NK = TIMEOUT + 3;
  localparam int VW = 4 + CW + CYCLE_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_completion_checker_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_CHECKS(NUM_CHECKS),
                                  .CYCLE_W(CYCLE_W)) bus();

  regfile_completion_checker #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_CHECKS(NUM_CHECKS),
                               .CYCLE_W(CYCLE_W), .TIMEOUT(TIMEOUT), .STABLE_CYCLES(STABLE))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural shadow, slot table, last reported result.
  logic [XLEN-1:0] m_shadow [NUM_REGS];
  logic            m_en     [NUM_CHECKS];
  logic [AW-1:0]   m_reg    [NUM_CHECKS];
  logic [XLEN-1:0] m_val    [NUM_CHECKS];
  logic [VW-1:0]   m_last;
  logic            sch_v [NK];
  logic [AW-1:0]   sch_a [NK];
  logic [XLEN-1:0] sch_d [NK];
  bit              noise = 1'b0;
  logic            mon_prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(bit ce, bit b, bit p, bit f, int fi, int cnt);
    return {ce, b, p, f, CW'(fi), CYCLE_W'(cnt)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.cfg_err, bus.busy, bus.pass, bus.fail, bus.fail_idx, bus.cycle_count};
  endfunction

  function automatic bit model_any_en();
    bit a = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) a |= m_en[i];
    return a;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) m_shadow[r] = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      m_en[i] = 1'b0; m_reg[i] = '0; m_val[i] = '0;
    end
    m_last = '0;
  endtask

  // RUN cycle k sees every write scheduled before k; outcome decided at the first
  // STABLE-long all-match streak, else at the TIMEOUT-th cycle.
  task automatic model_run(output logic [VW-1:0] e, output int kend);
    int streak = 0;
    bit decided = 1'b0;
    bit all_ok;
    int miss;
    bit any_on = model_any_en();
    e = '0;
    kend = NK - 1;
    for (int k = 0; k < NK; k++) begin
      if (!decided) begin
        all_ok = any_on;
        miss = -1;
        for (int i = 0; i < NUM_CHECKS; i++)
          if (m_en[i] && m_shadow[m_reg[i]] != m_val[i]) begin
            all_ok = 1'b0;
            if (miss < 0) miss = i;
          end
        streak = all_ok ? streak + 1 : 0;
        if (streak >= STABLE) begin
          decided = 1'b1; e = pack(0, 0, 1, 0, 0, k + 1); kend = k;
        end else if (k + 1 == TIMEOUT) begin
          decided = 1'b1; e = pack(0, 0, 0, 1, (miss < 0) ? 0 : miss, TIMEOUT); kend = k;
        end
      end
      if (sch_v[k] && sch_a[k] != '0) m_shadow[sch_a[k]] = sch_d[k];
    end
    m_last = e;
  endtask

  // Driver tasks: all start and end just after a falling edge.
  task automatic clear_sched();
    for (int k = 0; k < NK; k++) begin
      sch_v[k] = 1'b0; sch_a[k] = '0; sch_d[k] = '0;
    end
  endtask

  task automatic sched(int k, int a, logic [XLEN-1:0] d);
    sch_v[k] = 1'b1; sch_a[k] = AW'(a); sch_d[k] = d;
  endtask

  task automatic cfg_slot(int idx, bit en, int r, logic [XLEN-1:0] v);
    bus.cfg_we = 1'b1; bus.cfg_idx = CW'(idx); bus.cfg_en = en;
    bus.cfg_reg = AW'(r); bus.cfg_val = v;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    m_en[idx] = en; m_reg[idx] = AW'(r); m_val[idx] = v;
  endtask

  task automatic wr(int a, logic [XLEN-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (a != 0) m_shadow[a] = d;
  endtask

  task automatic do_run(input string name);
    logic [VW-1:0] e;
    int kend;
    model_run(e, kend);
    exp_q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < NK; k++) begin
      if (k == 0) check({name, "_busy"}, 32'(bus.busy), 32'd1);
      bus.wr_en = sch_v[k]; bus.wr_addr = sch_a[k]; bus.wr_data = sch_d[k];
      if (noise && k < kend) begin
        bus.cfg_we  = ($urandom_range(0, 3) == 0);
        bus.cfg_idx = CW'($urandom_range(0, NUM_CHECKS - 1));
        bus.cfg_en  = 1'($urandom_range(0, 1));
        bus.cfg_reg = AW'($urandom_range(0, 7));
        bus.cfg_val = XLEN'($urandom_range(0, 3));
        bus.start   = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      bus.wr_en = 1'b0; bus.cfg_we = 1'b0; bus.start = 1'b0;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic start_no_slots(input string name);
    exp_q.push_back(m_last | pack(1, 0, 0, 0, 0, 0));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: scores the result whenever done rises or cfg_err pulses.
  initial begin : monitor
    logic [VW-1:0] act, e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.cfg_err || (bus.done && !mon_prev_done))) begin
        act = dut_vec();
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got %h expected none", act);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(act), 32'(e));
        end
      end
      mon_prev_done = bus.done;
    end
  end

  initial begin : main
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_en = 0; bus.cfg_reg = '0; bus.cfg_val = '0;
    bus.start = 0;
    model_reset();
    clear_sched();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);

    // Single slot, write lands at RUN cycle 5.
    cfg_slot(0, 1, 2, 32'h40);
    clear_sched(); sched(5, 2, 32'h40);
    do_run("t1_single");

    // Timeout with a register that is never written; slot writes during RUN must be ignored.
    cfg_slot(0, 1, 2, 32'h03);
    clear_sched(); noise = 1'b1;
    do_run("t2_timeout");
    noise = 1'b0;

    // One matching cycle, a break, then a held match.
    cfg_slot(0, 1, 2, 32'h06);
    clear_sched(); sched(2, 2, 32'h06); sched(3, 2, 32'h05); sched(4, 2, 32'h06);
    do_run("t3_unstable");

    // Four slots, r3 missing.
    cfg_slot(0, 1, 1, 32'h11); cfg_slot(1, 1, 2, 32'h22);
    cfg_slot(2, 1, 3, 32'h33); cfg_slot(3, 1, 4, 32'h44);
    clear_sched(); sched(1, 1, 32'h11); sched(2, 2, 32'h22); sched(3, 4, 32'h44);
    do_run("t4_multi_fail");
    wr(3, 32'h33);
    clear_sched();
    do_run("t4_multi_pass");

    // x0 writes ignored; start with nothing enabled.
    cfg_slot(1, 0, 0, 0); cfg_slot(2, 0, 0, 0); cfg_slot(3, 0, 0, 0);
    cfg_slot(0, 1, 0, 32'h0);
    clear_sched(); sched(1, 0, 32'hFF); noise = 1'b1;
    do_run("t5_x0");
    noise = 1'b0;
    cfg_slot(0, 0, 0, 0);
    start_no_slots("t5_cfg_err");

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NUM_CHECKS; i++)
        cfg_slot(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), XLEN'($urandom_range(0, 3)));
      if (!model_any_en()) begin
        start_no_slots("rand_cfg_err");
        cfg_slot(0, 1, $urandom_range(0, 7), XLEN'($urandom_range(0, 3)));
      end
      repeat (2) wr($urandom_range(0, 7), XLEN'($urandom_range(0, 3)));
      clear_sched();
      for (int k = 0; k < TIMEOUT; k++)
        if ($urandom_range(0, 3) == 0) sched(k, $urandom_range(0, 7), XLEN'($urandom_range(0, 3)));
      noise = 1'b1;
      do_run("rand");
      noise = 1'b0;
    end

    // Asynchronous reset in the middle of a run.
    wr(2, 32'h40);
    cfg_slot(0, 1, 2, 32'h99);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_running", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_outputs", 32'(dut_vec()), 32'd0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    cfg_slot(0, 1, 2, 32'h0);
    clear_sched();
    do_run("t6_shadow_cleared");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
